wt_req_rr_arbiter: RTL and testbench



---
 rtl/wt_req_rr_arbiter.sv | 92 +++++++++
 tb/tb_wt_req_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_req_rr_arbiter.sv
// Round-robin arbiter sharing one word-write master port among NUM_REQ requesters.
// The winner's address/data are latched and held until the downstream grant, which is returned to the owner.
module wt_req_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   word_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        wt_req_o,
    output logic [ADDR_W-1:0]           wt_word_addr_o,
    output logic [DATA_W-1:0]           wt_data_o,
    input  logic                        wt_gnt_i,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic [CNT_W-1:0]            wr_cnt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] winner;
    logic             win_vld;

    // Scan starts just after the last winner, so the previous owner is always considered last.
    always_comb begin
        logic [IDX_W-1:0] idx;
        winner  = last_winner;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_winner) + i) % NUM_REQ);
            if (!win_vld && req_i[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state == BUSY && wt_gnt_i) begin
            gnt_o[owner_o] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            wt_req_o       <= 1'b0;
            busy_o         <= 1'b0;
            wt_word_addr_o <= '0;
            wt_data_o      <= '0;
            owner_o        <= '0;
            last_winner    <= IDX_W'(NUM_REQ - 1);
            wr_cnt_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner_o        <= winner;
                        wt_word_addr_o <= word_addr_i[winner*ADDR_W +: ADDR_W];
                        wt_data_o      <= data_i[winner*DATA_W +: DATA_W];
                        wt_req_o       <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    // Request inputs are ignored here: no preemption, latched payload stays stable.
                    if (wt_gnt_i) begin
                        last_winner <= owner_o;
                        wr_cnt_o    <= wr_cnt_o + 1'b1;
                        wt_req_o    <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wt_req_rr_arbiter.sv
// Scoreboard bench for wt_req_rr_arbiter: a transaction-level round-robin model predicts each grant,
// a negedge monitor pops and compares whenever a downstream grant is returned.
module tb_wt_req_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int CW = 4;

    logic              ACLK;
    logic              ARESETn;
    logic [NR-1:0]     req_i;
    logic [NR*AW-1:0]  word_addr_i;
    logic [NR*DW-1:0]  data_i;
    logic [NR-1:0]     gnt_o;
    logic              wt_req_o;
    logic [AW-1:0]     wt_word_addr_o;
    logic [DW-1:0]     wt_data_o;
    logic              wt_gnt_i;
    logic              busy_o;
    logic [1:0]        owner_o;
    logic [CW-1:0]     wr_cnt_o;

    wt_req_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .req_i(req_i), .word_addr_i(word_addr_i),
        .data_i(data_i), .gnt_o(gnt_o), .wt_req_o(wt_req_o), .wt_word_addr_o(wt_word_addr_o),
        .wt_data_o(wt_data_o), .wt_gnt_i(wt_gnt_i), .busy_o(busy_o), .owner_o(owner_o),
        .wr_cnt_o(wr_cnt_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    bit            exp_gnt = 1'b0;

    // Requester-side model state
    logic [NR-1:0] pend;
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    int            last;
    int            cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] p, input int lst);
        for (int i = 1; i <= NR; i++) begin
            if (p[(lst + i) % NR]) return (lst + i) % NR;
        end
        return -1;
    endfunction

    task automatic apply();
        req_i = pend;
        for (int k = 0; k < NR; k++) begin
            word_addr_i[k*AW +: AW] = a[k];
            data_i[k*DW +: DW]      = d[k];
        end
    endtask

    task automatic raise(input int k);
        if (!pend[k]) begin
            pend[k] = 1'b1;
            a[k]    = AW'($urandom);
            d[k]    = $urandom;
        end
    endtask

    task automatic reset_dut();
        ARESETn  = 1'b0;
        wt_gnt_i = 1'b0;
        pend     = '0;
        apply();
        sb_q.delete();
        last = NR - 1;
        cnt  = 0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
    endtask

    // Entered with the DUT idle and the pending set already driven; keep: 0 drop, 1 hold, 2 random.
    task automatic run_txn(input int lat, input bit mess, input int keep, output int w);
        exp_t e;
        int   k;
        w = rr_pick(pend, last);
        e.w = w; e.a = a[w]; e.d = d[w];
        sb_q.push_back(e);
        chk("req_latency_pre", 64'(wt_req_o), 64'(0));
        @(posedge ACLK); #1;
        chk("req_latency", 64'(wt_req_o), 64'(1));
        chk("busy", 64'(busy_o), 64'(1));
        chk("latched_addr", 64'(wt_word_addr_o), 64'(e.a));
        chk("latched_data", 64'(wt_data_o), 64'(e.d));
        repeat (lat) begin
            if (mess) begin
                k = int'($urandom_range(NR-1, 0));
                if (k != w && $urandom_range(3, 0) == 0) raise(k);
                if ($urandom_range(3, 0) == 0) begin
                    a[w]    = AW'($urandom);
                    d[w]    = $urandom;
                    pend[w] = 1'($urandom_range(1, 0));
                end
                apply();
            end
            @(posedge ACLK); #1;
        end
        exp_gnt  = 1'b1;
        wt_gnt_i = 1'b1;
        @(posedge ACLK); #1;
        exp_gnt  = 1'b0;
        wt_gnt_i = 1'b0;
        last = w;
        cnt  = (cnt + 1) % (1 << CW);
        chk("wr_cnt", 64'(wr_cnt_o), 64'(cnt));
        chk("req_drop", 64'(wt_req_o), 64'(0));
        chk("busy_drop", 64'(busy_o), 64'(0));
        if (keep == 1 || (keep == 2 && $urandom_range(1, 0) == 1)) begin
            pend[w] = 1'b1;
            a[w]    = AW'($urandom);
            d[w]    = $urandom;
        end else begin
            pend[w] = 1'b0;
        end
        apply();
    endtask

    task automatic idle_gnt();
        exp_gnt  = 1'b0;
        wt_gnt_i = 1'b1;
        @(posedge ACLK); #1;
        wt_gnt_i = 1'b0;
        chk("idle_gnt_cnt", 64'(wr_cnt_o), 64'(cnt));
        chk("idle_gnt_req", 64'(wt_req_o), 64'(0));
    endtask

    // Monitor: a grant pulse is only legal when the bench returns the downstream grant in BUSY.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (exp_gnt) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: grant with no expected transaction, gnt_o=%b", gnt_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("gnt_onehot", 64'(gnt_o), 64'(1) << e.w);
                    chk("owner", 64'(owner_o), 64'(e.w));
                    chk("sb_addr", 64'(wt_word_addr_o), 64'(e.a));
                    chk("sb_data", 64'(wt_data_o), 64'(e.d));
                end
            end else begin
                chk("gnt_idle", 64'(gnt_o), 64'(0));
            end
        end
    end

    initial begin
        int w;
        int order[5] = '{0, 1, 2, 3, 0};
        wt_gnt_i = 1'b0;
        for (int k = 0; k < NR; k++) begin
            a[k] = '0;
            d[k] = '0;
        end
        reset_dut();
        chk("rst_req", 64'(wt_req_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_owner", 64'(owner_o), 64'(0));
        chk("rst_cnt", 64'(wr_cnt_o), 64'(0));
        chk("rst_addr", 64'(wt_word_addr_o), 64'(0));
        chk("rst_data", 64'(wt_data_o), 64'(0));

        // Single requester 2, downstream grant 3 cycles after wt_req_o
        pend = 4'b0100; a[2] = AW'(32'h100); d[2] = 32'hDEADBEEF;
        apply();
        run_txn(3, 1'b0, 0, w);
        chk("single_winner", 64'(w), 64'(2));
        chk("single_cnt", 64'(wr_cnt_o), 64'(1));

        // All requesting from reset and held after grants
        reset_dut();
        for (int k = 0; k < NR; k++) raise(k);
        apply();
        for (int i = 0; i < 5; i++) begin
            run_txn(int'($urandom_range(2, 0)), 1'b0, 1, w);
            chk("rr_order", 64'(w), 64'(order[i]));
        end
        chk("rr_cnt5", 64'(wr_cnt_o), 64'(5));

        // Requester 1 wins, then 1010 pending -> 3 then 1
        reset_dut();
        raise(1); apply();
        run_txn(1, 1'b0, 1, w);
        chk("w1", 64'(w), 64'(1));
        raise(3); apply();
        run_txn(1, 1'b0, 0, w);
        chk("w3", 64'(w), 64'(3));
        run_txn(0, 1'b0, 0, w);
        chk("w1_again", 64'(w), 64'(1));
        idle_gnt();

        // Reset in the middle of a transaction
        reset_dut();
        pend = 4'b0110; apply();
        @(posedge ACLK); #1;
        chk("mid_req", 64'(wt_req_o), 64'(1));
        chk("mid_owner", 64'(owner_o), 64'(1));
        ARESETn = 1'b0;
        #1;
        chk("async_req", 64'(wt_req_o), 64'(0));
        chk("async_busy", 64'(busy_o), 64'(0));
        chk("async_owner", 64'(owner_o), 64'(0));
        pend = '0; apply();
        last = NR - 1; cnt = 0;
        @(posedge ACLK); #1 ARESETn = 1'b1;
        idle_gnt();
        for (int k = 0; k < NR; k++) raise(k);
        apply();
        run_txn(1, 1'b0, 0, w);
        chk("post_rst_prio", 64'(w), 64'(0));

        // Randomized traffic with busy-time disturbance; counter wraps at 2^CW
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            if (pend == 0) begin
                if ($urandom_range(3, 0) == 0) idle_gnt();
                for (int k = 0; k < NR; k++) if ($urandom_range(1, 0) == 1) raise(k);
                if (pend == 0) raise(int'($urandom_range(NR-1, 0)));
                apply();
            end
            run_txn(int'($urandom_range(3, 0)), 1'b1, 2, w);
            if (i == 15) chk("cnt_wrap", 64'(wr_cnt_o), 64'(0));
        end
        pend = '0; apply();
        repeat (2) @(posedge ACLK);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
